wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the dual-issue core's register file. Collects results from NUM_REQ completion units through per-unit valid/ready handshakes, buffers one result per unit, and drives the register file's two write ports (write1/rd1/write1_data, write2/rd2/write2_data) with round-robin fairness. It sits between the execution units and the register file.

## Interface

- NUM_REQ, 4, number of requesting completion units (2..8)
- XLEN, 32, result data width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  per-unit result valid
- req_ready  output  NUM_REQ  per-unit ready; a transfer occurs when valid and ready are both high at a rising edge
- req_rd  input  5*NUM_REQ  destination register per unit; unit i uses bits [5i+4:5i]
- req_data  input  XLEN*NUM_REQ  result per unit; unit i uses bits [XLEN*i+XLEN-1:XLEN*i]
- write1  output  1  register file write enable, port 1
- rd1  output  5  port 1 destination
- write1_data  output  XLEN  port 1 data
- write2  output  1  register file write enable, port 2
- rd2  output  5  port 2 destination
- write2_data  output  XLEN  port 2 data
- busy  output  1  at least one slot occupied

## Operation

- One holding slot per unit: slot_valid[i], slot_rd[i], slot_data[i].
- req_ready[i] = !rst && (!slot_valid[i] || grant[i]). It is combinational from slot state and grants only, never from req_valid.
- Accept with req_rd == 0: handshake completes and the result is discarded. The slot is not loaded.
- Accept with rd != 0: the slot loads rd and data at the edge.
- Arbitration is combinational over occupied slots, scanned in order ptr, ptr+1, …, wrapping modulo NUM_REQ:
  - first occupied slot → port 1 grant
  - next eligible occupied slot → port 2 grant
  - at most 2 grants per cycle
- At the edge, granted slots are cleared, unless the same edge accepts a new result into that slot, in which case the slot reloads.
- Registered outputs at each edge:
  - write1 <= port-1 grant exists; rd1/write1_data <= that slot's contents
  - likewise for port 2
  - with no grant, the write enable is 0 and rd/data are 0.
- ptr <= (index of last granted slot + 1) mod NUM_REQ; ptr is unchanged if there is no grant.
- busy = OR of slot_valid.
- Reset (async, any time, including mid-transfer) sets:
  - all slot_valid = 0, ptr = 0
  - write1 = write2 = 0, rd1 = rd2 = 0, write1_data = write2_data = 0
  - req_ready = 0 while rst is high, and all 1 in the first cycle after release
  - Buffered results are lost.

## Timing

- Latency: a result accepted at edge N appears on a write port after edge N+1 (write asserted during cycle N+1..N+2). This is the minimum; it grows under contention.
- Throughput: 2 writes per cycle total. A single unit can sustain 1 result per cycle while it wins every cycle.
- Fairness: any occupied slot is granted within ceil(NUM_REQ/2) cycles (NUM_REQ cycles with same-rd deferral).
- Port ordering: port 1 is always the slot earlier in round-robin order. write2 is never asserted in a cycle where write1 is 0.

## Configuration

- WB_SAME_RD_CHECK_EN defined:
  - a candidate whose slot_rd equals the port-1 winner's rd is not eligible for port 2 this cycle
  - the scan continues to the next occupied slot with a different rd; if none exists, port 2 stays idle
  - guarantees rd1 != rd2 whenever both writes are asserted.
- Not defined: port 2 takes the next occupied slot regardless of rd. Both ports may target the same register in one cycle, and the register file's write-port priority decides the outcome.

## Test plan

- Reset check: assert rst mid-stream with 3 slots loaded → immediately write1 = write2 = 0, rd/data = 0, busy = 0, req_ready = 0. After release, req_ready = 4'b1111 and no stale writes appear.
- Single result: unit 2 sends rd = 5, data = 0xDEADBEEF at edge N → write1 = 1, rd1 = 5, write1_data = 0xDEADBEEF during cycle N+1; write2 = 0; busy falls after N+1.
- Contention and round-robin: all 4 units valid every cycle with distinct rd, ptr = 0 → grant pairs {0,1}, {2,3}, {0,1}, …. Each unit is accepted every other cycle, and no unit waits more than 2 cycles.
- rd = 0 drop: unit 1 sends rd = 0, data = 0x1234 → handshake completes, no write on either port, busy stays 0.
- Same-rd conflict: units 0 and 1 both hold rd = 7 and unit 2 holds rd = 9, ptr = 0.
  - With WB_SAME_RD_CHECK_EN: cycle 1 writes rd1 = 7 (unit 0) and rd2 = 9 (unit 2); cycle 2 writes rd1 = 7 (unit 1).
  - Without it: cycle 1 writes rd1 = 7 and rd2 = 7 (units 0, 1); cycle 2 writes rd1 = 9.
- Back-to-back single unit: unit 3 valid for 5 consecutive cycles, others idle → req_ready[3] stays 1 and write1 is asserted for 5 consecutive cycles, in input order.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per completion unit, drained round-robin onto two
// register-file write ports. Define WB_SAME_RD_CHECK_EN to keep rd1 != rd2 on dual writes.
module wb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_rd,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  output logic                    write1,
  output logic [4:0]              rd1,
  output logic [XLEN-1:0]         write1_data,
  output logic                    write2,
  output logic [4:0]              rd2,
  output logic [XLEN-1:0]         write2_data,
  output logic                    busy
);

  localparam int unsigned     PtrW    = $clog2(NUM_REQ);
  localparam logic [PtrW:0]   NumReqW = (PtrW+1)'(NUM_REQ);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);
`ifdef WB_SAME_RD_CHECK_EN
  localparam bit SameRdCheck = 1'b1;
`else
  localparam bit SameRdCheck = 1'b0;
`endif

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  logic [4:0]         slot_rd_q   [NUM_REQ];
  logic [4:0]         slot_rd_d   [NUM_REQ];
  logic [XLEN-1:0]    slot_data_q [NUM_REQ];
  logic [XLEN-1:0]    slot_data_d [NUM_REQ];
  logic [PtrW-1:0]    ptr_q, ptr_d;

  logic               write1_q, write1_d, write2_q, write2_d;
  logic [4:0]         rd1_q, rd1_d, rd2_q, rd2_d;
  logic [XLEN-1:0]    data1_q, data1_d, data2_q, data2_d;

  logic               g1_vld, g2_vld;
  logic [PtrW-1:0]    g1_idx, g2_idx, last_idx;
  logic [NUM_REQ-1:0] grant;

  // Scan occupied slots starting at ptr; port 1 takes the first, port 2 the next eligible.
  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;
    sum    = '0;
    idx    = '0;
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1_idx = '0;
    g2_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (sum >= NumReqW) sum = sum - NumReqW;
      idx = sum[PtrW-1:0];
      if (slot_valid_q[idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = idx;
        end else if (!g2_vld && (!SameRdCheck || (slot_rd_q[idx] != slot_rd_q[g1_idx]))) begin
          g2_vld = 1'b1;
          g2_idx = idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g1_vld) grant[g1_idx] = 1'b1;
    if (g2_vld) grant[g2_idx] = 1'b1;
  end

  assign req_ready = {NUM_REQ{!rst}} & (~slot_valid_q | grant);
  assign busy      = |slot_valid_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_rd_d    = slot_rd_q;
    slot_data_d  = slot_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A fresh result in a granted slot wins over the clear; rd 0 results are dropped.
      if (req_valid[i] && req_ready[i] && (req_rd[5*i +: 5] != 5'd0)) begin
        slot_valid_d[i] = 1'b1;
        slot_rd_d[i]    = req_rd[5*i +: 5];
        slot_data_d[i]  = req_data[XLEN*i +: XLEN];
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end

    write1_d = g1_vld;
    rd1_d    = g1_vld ? slot_rd_q[g1_idx]   : '0;
    data1_d  = g1_vld ? slot_data_q[g1_idx] : '0;
    write2_d = g2_vld;
    rd2_d    = g2_vld ? slot_rd_q[g2_idx]   : '0;
    data2_d  = g2_vld ? slot_data_q[g2_idx] : '0;

    last_idx = g2_vld ? g2_idx : g1_idx;
    ptr_d    = ptr_q;
    if (g1_vld) ptr_d = (last_idx == LastIdx) ? '0 : last_idx + PtrW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      ptr_q        <= '0;
      write1_q     <= 1'b0;
      rd1_q        <= '0;
      data1_q      <= '0;
      write2_q     <= 1'b0;
      rd2_q        <= '0;
      data2_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_rd_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_rd_q    <= slot_rd_d;
      slot_data_q  <= slot_data_d;
      ptr_q        <= ptr_d;
      write1_q     <= write1_d;
      rd1_q        <= rd1_d;
      data1_q      <= data1_d;
      write2_q     <= write2_d;
      rd2_q        <= rd2_d;
      data2_q      <= data2_d;
    end
  end

  assign write1      = write1_q;
  assign rd1         = rd1_q;
  assign write1_data = data1_q;
  assign write2      = write2_q;
  assign rd2         = rd2_q;
  assign write2_data = data2_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based round-robin model, plus directed
// scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int N = 4;
  localparam int X = 32;
`ifdef WB_SAME_RD_CHECK_EN
  localparam bit Same = 1'b1;
  localparam int FairBound = N;
`else
  localparam bit Same = 1'b0;
  localparam int FairBound = (N + 1) / 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_rd = '0;
  logic [X*N-1:0] req_data = '0;
  logic           write1, write2, busy;
  logic [4:0]     rd1, rd2;
  logic [X-1:0]   write1_data, write2_data;

  wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_data(req_data), .write1(write1), .rd1(rd1), .write1_data(write1_data),
    .write2(write2), .rd2(rd2), .write2_data(write2_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: slot contents, rr pointer, age of each occupant, and the registered outputs.
  bit         m_valid [N];
  logic [4:0] m_rd    [N];
  logic [X-1:0] m_data [N];
  int         m_age   [N];
  int         m_ptr;
  logic       e_w1, e_w2;
  logic [4:0] e_rd1, e_rd2;
  logic [X-1:0] e_d1, e_d2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_rd[i]    = '0;
      m_data[i]  = '0;
      m_age[i]   = 0;
    end
    m_ptr = 0;
    e_w1 = 1'b0; e_w2 = 1'b0; e_rd1 = '0; e_rd2 = '0; e_d1 = '0; e_d2 = '0;
  endfunction

  function automatic void arbitrate(output int g1, output int g2);
    int order[$];
    for (int k = 0; k < N; k++)
      if (m_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    g1 = -1;
    g2 = -1;
    if (order.size() > 0) g1 = order[0];
    for (int k = 1; k < order.size(); k++) begin
      if (g2 < 0 && (!Same || m_rd[order[k]] != m_rd[g1])) g2 = order[k];
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, check every output, then advance the model
  // across the following rising edge.
  task automatic drive(input logic [N-1:0] v, input logic [5*N-1:0] rd, input logic [X*N-1:0] d);
    int g1, g2;
    logic [N-1:0] er;
    bit eb;
    @(negedge clk);
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
    #1;
    arbitrate(g1, g2);
    eb = 1'b0;
    for (int i = 0; i < N; i++) begin
      er[i] = !m_valid[i] || (i == g1) || (i == g2);
      eb    = eb | m_valid[i];
    end
    chk("req_ready", req_ready, er);
    chk("busy", busy, eb);
    chk("write1", write1, e_w1);
    chk("rd1", rd1, e_rd1);
    chk("write1_data", write1_data, e_d1);
    chk("write2", write2, e_w2);
    chk("rd2", rd2, e_rd2);
    chk("write2_data", write2_data, e_d2);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        m_age[i]++;
        if (i == g1 || i == g2) chk("fair_wait_ok", m_age[i] <= FairBound, 1);
      end
    end
    e_w1 = (g1 >= 0); e_rd1 = '0; e_d1 = '0;
    e_w2 = (g2 >= 0); e_rd2 = '0; e_d2 = '0;
    if (g1 >= 0) begin e_rd1 = m_rd[g1]; e_d1 = m_data[g1]; end
    if (g2 >= 0) begin e_rd2 = m_rd[g2]; e_d2 = m_data[g2]; end
    if (g2 >= 0) m_ptr = (g2 + 1) % N;
    else if (g1 >= 0) m_ptr = (g1 + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && er[i] && rd[5*i +: 5] != 5'd0) begin
        m_valid[i] = 1'b1;
        m_rd[i]    = rd[5*i +: 5];
        m_data[i]  = d[X*i +: X];
        m_age[i]   = 0;
      end else if (i == g1 || i == g2) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_write1", write1, 0);
    chk("rst_write2", write2, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_rd2", rd2, 0);
    chk("rst_data1", write1_data, 0);
    chk("rst_data2", write2_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 4'b0000);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("ready_after_rst", req_ready, 4'b1111);
  endtask

  initial begin
    logic [5*N-1:0] rdv;
    logic [X*N-1:0] dv;
    logic [4:0] x_rd1a, x_rd2a, x_rd1b;
    logic x_w2a;

    model_clear();
    #12;
    chk("init_ready", req_ready, 4'b0000);
    chk("init_write1", write1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single result from unit 2.
    rdv = '0; dv = '0;
    rdv[10 +: 5] = 5'd5;
    dv[64 +: 32] = 32'hDEADBEEF;
    drive(4'b0100, rdv, dv);
    drive('0, '0, '0);
    @(posedge clk); #1;
    chk("single_write1", write1, 1);
    chk("single_rd1", rd1, 5);
    chk("single_data1", write1_data, 32'hDEADBEEF);
    chk("single_write2", write2, 0);
    chk("single_busy", busy, 0);

    // rd 0 is accepted and dropped.
    rdv = '0; dv = '0;
    dv[32 +: 32] = 32'h1234;
    drive(4'b0010, rdv, dv);
    chk("drop_ready", req_ready[1], 1);
    @(posedge clk); #1;
    chk("drop_busy", busy, 0);
    drive('0, '0, '0);
    @(posedge clk); #1;
    chk("drop_write1", write1, 0);
    chk("drop_write2", write2, 0);

    // Same-rd conflict from ptr 0.
    reset_mid();
    rdv = '0; dv = '0;
    rdv[0 +: 5] = 5'd7; rdv[5 +: 5] = 5'd7; rdv[10 +: 5] = 5'd9;
    dv[0 +: 32] = 32'hA0; dv[32 +: 32] = 32'hA1; dv[64 +: 32] = 32'hA2;
`ifdef WB_SAME_RD_CHECK_EN
    x_rd1a = 5'd7; x_rd2a = 5'd9; x_rd1b = 5'd7;
`else
    x_rd1a = 5'd7; x_rd2a = 5'd7; x_rd1b = 5'd9;
`endif
    x_w2a = 1'b1;
    drive(4'b0111, rdv, dv);
    drive('0, '0, '0);
    @(posedge clk); #1;
    chk("samerd_c1_write2", write2, x_w2a);
    chk("samerd_c1_rd1", rd1, x_rd1a);
    chk("samerd_c1_rd2", rd2, x_rd2a);
    drive('0, '0, '0);
    @(posedge clk); #1;
    chk("samerd_c2_write1", write1, 1);
    chk("samerd_c2_rd1", rd1, x_rd1b);
    chk("samerd_c2_write2", write2, 0);

    // Full contention, distinct rd per unit.
    reset_mid();
    for (int c = 0; c < 6; c++) begin
      rdv = '0; dv = '0;
      for (int i = 0; i < N; i++) begin
        rdv[5*i +: 5] = 5'(i + 1);
        dv[X*i +: X]  = 32'(c * 16 + i);
      end
      drive(4'b1111, rdv, dv);
      if (c > 0) begin
        @(posedge clk); #1;
        chk("rr_write2", write2, 1);
        chk("rr_rd1", rd1, (c % 2 == 1) ? 1 : 3);
        chk("rr_rd2", rd2, (c % 2 == 1) ? 2 : 4);
      end
    end
    reset_mid();

    // Back-to-back results from unit 3.
    drive('0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      rdv = '0; dv = '0;
      rdv[15 +: 5] = 5'(10 + c);
      dv[96 +: 32] = 32'(100 + c);
      drive(4'b1000, rdv, dv);
      chk("b2b_ready3", req_ready[3], 1);
      if (c > 0) begin
        @(posedge clk); #1;
        chk("b2b_write1", write1, 1);
        chk("b2b_rd1", rd1, 10 + c - 1);
      end
    end
    drive('0, '0, '0);
    @(posedge clk); #1;
    chk("b2b_last_rd1", rd1, 14);

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 9) < 6);
        rdv[5*i +: 5] = 5'($urandom_range(0, 7));
        dv[X*i +: X]  = $urandom;
      end
      drive(v, rdv, dv);
      if (c == 1500) reset_mid();
    end
    drive('0, '0, '0);
    drive('0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
